// File: rtl/miriscv_pic.sv
// miriscv_pic -- programmable interrupt controller for the miriscv core.
//
// Sits between the peripheral interrupt lines and the core's interrupt pins.
// Each channel is either rising-edge sensitive (sticky pending bit that
// survives masking) or level sensitive (follows the sampled request line).
// One interrupt is latched at a time. The core acknowledges completion with a
// single-cycle int_rst_i pulse, and the serviced peripheral then receives a
// one-cycle one-hot int_fin_o.
//
// Parameters:
//   NUM_IRQ    number of channels (1..32)
//   EDGE_MASK  bit i = 1 -> channel i is rising-edge sensitive, 0 -> level
//   ARB_RR     0 = fixed priority (lowest index wins), 1 = round-robin
//   CAUSE_BASE added to the granted channel index to form mcause
//
// Ports:
//   clk_i      system clock
//   rst_n_i    asynchronous active-low reset
//   int_req_i  peripheral request lines
//   mie_i      per-channel enable from the core's mie CSR
//   int_rst_i  handler-finished pulse from the core (mret)
//   int_o      interrupt request to the core (registered)
//   int_fin_o  one-hot, one-cycle acknowledge to the serviced peripheral
//   mcause_o   cause code of the latched interrupt
//
// State    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for an enabled candidate; latches idx and mcause
// SERVICE  | int_o high, waiting for int_rst_i from the core
// FIN      | int_fin_o[idx] high for this one cycle, then back to IDLE

module miriscv_pic #(
    parameter int          NUM_IRQ    = 32,
    parameter logic [31:0] EDGE_MASK  = 32'h0000_0000,
    parameter int          ARB_RR     = 0,
    parameter logic [31:0] CAUSE_BASE = 32'h0000_0010
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_IRQ-1:0] int_req_i,
    input  logic [NUM_IRQ-1:0] mie_i,
    input  logic               int_rst_i,
    output logic               int_o,
    output logic [NUM_IRQ-1:0] int_fin_o,
    output logic [31:0]        mcause_o
);

    localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam int PW = IW + 1;
    localparam logic [NUM_IRQ-1:0] EDGE_M   = EDGE_MASK[NUM_IRQ-1:0];
    localparam logic [IW-1:0]      LAST_IDX = IW'(NUM_IRQ - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVICE = 2'd1,
        FIN     = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_n;
    logic [NUM_IRQ-1:0]  req_q;
    logic [NUM_IRQ-1:0]  pend_q;
    logic [NUM_IRQ-1:0]  pend_n;
    logic [NUM_IRQ-1:0]  pend_set;
    logic [NUM_IRQ-1:0]  pend_clr;
    logic [NUM_IRQ-1:0]  cand;
    logic [NUM_IRQ-1:0]  idx_hot;
    logic [IW-1:0]       idx_q;
    logic [IW-1:0]       last_q;
    logic [IW-1:0]       start;
    logic [IW-1:0]       grant;
    logic [PW-1:0]       pos;
    logic                found;
    logic                svc_done;

    assign svc_done = (state_q == SERVICE) && int_rst_i;

    always_comb begin
        idx_hot        = '0;
        idx_hot[idx_q] = 1'b1;
    end

    // Set has priority over clear, so an edge arriving on the same clock as
    // the finish of that channel's service is not lost.
    assign pend_set = int_req_i & ~req_q & EDGE_M;
    assign pend_clr = svc_done ? (idx_hot & EDGE_M) : '0;
    assign pend_n   = ((pend_q & ~pend_clr) | pend_set) & EDGE_M;

    assign cand = ((pend_q & EDGE_M) | (req_q & ~EDGE_M)) & mie_i;

    // Circular search starting at 'start'. Fixed priority always starts at
    // channel 0; round-robin starts one above the last serviced channel.
    always_comb begin
        start = '0;
        if (ARB_RR != 0 && last_q != LAST_IDX) begin
            start = last_q + IW'(1);
        end
        found = 1'b0;
        grant = '0;
        pos   = '0;
        for (int off = 0; off < NUM_IRQ; off++) begin
            pos = {1'b0, start} + PW'(off);
            if (pos >= PW'(NUM_IRQ)) begin
                pos = pos - PW'(NUM_IRQ);
            end
            if (!found && cand[pos[IW-1:0]]) begin
                found = 1'b1;
                grant = pos[IW-1:0];
            end
        end
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    if (found)     state_n = SERVICE;
            SERVICE: if (int_rst_i) state_n = FIN;
            FIN:                    state_n = IDLE;
            default:                state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            req_q     <= '0;
            pend_q    <= '0;
            idx_q     <= '0;
            last_q    <= LAST_IDX;
            int_o     <= 1'b0;
            int_fin_o <= '0;
            mcause_o  <= '0;
        end else begin
            state_q   <= state_n;
            req_q     <= int_req_i;
            pend_q    <= pend_n;
            int_o     <= (state_n == SERVICE);
            int_fin_o <= (state_n == FIN) ? idx_hot : '0;
            if (state_q == IDLE && found) begin
                idx_q    <= grant;
                mcause_o <= 32'h8000_0000 | (CAUSE_BASE + 32'(grant));
            end
            if (svc_done) begin
                last_q <= idx_q;
            end
        end
    end

endmodule
